// File: rtl/vx_gpu_req_arb.sv
// rtl/vx_gpu_req_arb.sv - round-robin arbiter feeding one GPU unit through a registered stage
module vx_gpu_req_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid_in,
  input  logic [NUM_REQS*DATAW-1:0] req_data_in,
  output logic [NUM_REQS-1:0]       req_ready_in,
  output logic                      req_valid_out,
  output logic [DATAW-1:0]          req_data_out,
  output logic [LOG_NUM_REQS-1:0]   req_sel_out,
  input  logic                      req_ready_out
);

  logic [LOG_NUM_REQS-1:0] rr_ptr;
  logic [LOG_NUM_REQS-1:0] grant_idx;
  logic [LOG_NUM_REQS-1:0] next_ptr;
  logic                    grant_valid;
  logic [DATAW-1:0]        grant_data;
  logic                    en;

  // Slot index reached k steps after the round-robin pointer, wrapping at NUM_REQS
  function automatic int wrap_idx(input logic [LOG_NUM_REQS-1:0] ptr, input int k);
    int idx;
    idx = int'(ptr) + k;
    if (idx >= NUM_REQS) idx = idx - NUM_REQS;
    return idx;
  endfunction

  // The output stage can take a new packet when empty or draining this cycle;
  // held low during reset so no slot sees an accept
  assign en = (!req_valid_out || req_ready_out) && !reset;

  // Scan from the farthest offset back to the pointer so the nearest valid slot wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (req_valid_in[wrap_idx(rr_ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = LOG_NUM_REQS'(wrap_idx(rr_ptr, k));
      end
    end
  end

  // Winner's packet, ready strobe, and the pointer value that makes it lowest priority
  always_comb begin
    grant_data   = '0;
    req_ready_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == LOG_NUM_REQS'(i)) begin
        grant_data      = req_data_in[i*DATAW +: DATAW];
        req_ready_in[i] = grant_valid && en;
      end
    end
    if (grant_idx == LOG_NUM_REQS'(NUM_REQS - 1)) next_ptr = '0;
    else next_ptr = grant_idx + LOG_NUM_REQS'(1);
  end

  // Registered output stage; pointer only moves when a slot is actually accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_out <= 1'b0;
      req_data_out  <= '0;
      req_sel_out   <= '0;
      rr_ptr        <= '0;
    end else if (en) begin
      req_valid_out <= grant_valid;
      if (grant_valid) begin
        req_data_out <= grant_data;
        req_sel_out  <= grant_idx;
        rr_ptr       <= next_ptr;
      end
    end
  end

  // A stalled packet must not change underneath the unit
  property p_hold_stable;
    @(posedge clk) disable iff (reset)
      (req_valid_out && !req_ready_out) |=> ($stable(req_data_out) && $stable(req_sel_out));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

endmodule
